// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the burst data fetcher.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  // Total bus words in one image.
  function automatic int calc_total(input int num_ch, input int words_per_ch);
    return num_ch * words_per_ch;
  endfunction

  // Elements packed into one bus word.
  function automatic int calc_epw(input int bus_w, input int elem_w);
    return bus_w / elem_w;
  endfunction

endpackage

// File: rtl/fetch_resp_buf.sv
// Circular response buffer holding read words until the unpacker consumes them.
// Push and pop may occur in the same cycle; occupancy is then unchanged.
module fetch_resp_buf
  import fetch_pkg::*;
#(
  parameter int BUS_W = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = sel_width(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [BUS_W-1:0] push_data,
  input  logic             pop,
  output logic [BUS_W-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Word storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/burst_data_fetcher.sv
// Avalon-MM burst read master that streams an image into per-channel FIFOs.
// Optional build macro FETCH_STATS_EN adds saturating stall counters.
module burst_data_fetcher
  import fetch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int BUS_W        = 64,
  parameter int ELEM_W       = 8,
  parameter int NUM_CH       = 9,
  parameter int WORDS_PER_CH = 1,
  parameter int MAX_OUT      = 4,
  localparam int SEL_W       = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [BUS_W-1:0]  mem_readdata,
  input  logic              mem_readdatavalid,
  input  logic              mem_waitrequest,
  output logic [ELEM_W-1:0] fifo_data,
  output logic [SEL_W-1:0]  fifo_sel,
  output logic              fifo_wren,
  input  logic [NUM_CH-1:0] fifo_full
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       stall_wait,
  output logic [15:0]       stall_full
`endif
);

  localparam int TOTAL  = calc_total(NUM_CH, WORDS_PER_CH);
  localparam int EPW    = calc_epw(BUS_W, ELEM_W);
  localparam int IW     = cnt_width(TOTAL);
  localparam int CW     = cnt_width(MAX_OUT);
  localparam int EW     = sel_width(EPW);
  localparam int WW     = sel_width(WORDS_PER_CH);
  localparam int FULL_W = 1 << SEL_W;

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     issued;
  logic [IW-1:0]     words_done;
  logic [CW-1:0]     credits;
  logic [CW-1:0]     buf_count;
  logic [EW-1:0]     elem_idx;
  logic [WW-1:0]     word_in_ch;
  logic [SEL_W-1:0]  ch;
  logic [BUS_W-1:0]  head_data;
  logic [FULL_W-1:0] full_ext;
  logic [ELEM_W-1:0] elem;
  logic              active;
  logic              start_acc;
  logic              accept;
  logic              push;
  logic              pop;
  logic              buf_empty;
  logic              elem_pend;
  logic              chan_full;
  logic              last_elem;
  logic              last_word;

  assign active    = (state == ISSUE) || (state == DRAIN);
  assign start_acc = (state == IDLE) && start;
  assign busy      = active;
  assign done      = (state == DONE);

  // Issue while words remain and a buffer slot is reserved for the reply.
  assign mem_read  = (state == ISSUE) && (issued < IW'(TOTAL)) && (credits != '0);
  assign accept    = mem_read && !mem_waitrequest;

  // Responses outside an active fetch are stale and dropped.
  assign push      = mem_readdatavalid && active && ((buf_count != CW'(MAX_OUT)) || pop);

  assign full_ext  = FULL_W'(fifo_full);
  assign elem_pend = !buf_empty;
  assign chan_full = full_ext[ch];
  assign fifo_wren = elem_pend && !chan_full;
  assign last_elem = (elem_idx == EW'(EPW - 1));
  assign pop       = fifo_wren && last_elem;
  assign last_word = (words_done == IW'(TOTAL - 1));

  assign fifo_data = elem_pend ? elem : '0;
  assign fifo_sel  = elem_pend ? ch : '0;

  fetch_resp_buf #(
    .BUS_W (BUS_W),
    .DEPTH (MAX_OUT)
  ) u_resp_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (mem_readdata),
    .pop       (pop),
    .head_data (head_data),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // Select the current element of the head word, most significant first.
  always_comb begin
    elem = '0;
    for (int i = 0; i < EPW; i++) begin
      if (elem_idx == EW'(i)) elem = head_data[BUS_W-1-i*ELEM_W -: ELEM_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE: begin
        if (pop && last_word)                       state_nxt = DONE;
        else if (accept && issued == IW'(TOTAL - 1)) state_nxt = DRAIN;
      end
      DRAIN:   if (pop && last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue address, credit pool and unpack position.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_address <= '0;
      issued      <= '0;
      credits     <= '0;
      words_done  <= '0;
      elem_idx    <= '0;
      word_in_ch  <= '0;
      ch          <= '0;
    end else if (start_acc) begin
      mem_address <= base_addr;
      issued      <= '0;
      credits     <= CW'(MAX_OUT);
      words_done  <= '0;
      elem_idx    <= '0;
      word_in_ch  <= '0;
      ch          <= '0;
    end else begin
      if (accept) begin
        issued      <= issued + 1'b1;
        mem_address <= mem_address + 1'b1;
      end
      case ({accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
      if (fifo_wren) elem_idx <= last_elem ? '0 : elem_idx + 1'b1;
      if (pop) begin
        words_done <= words_done + 1'b1;
        if (word_in_ch == WW'(WORDS_PER_CH - 1)) begin
          word_in_ch <= '0;
          ch         <= ch + 1'b1;
        end else begin
          word_in_ch <= word_in_ch + 1'b1;
        end
      end
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // Saturating stall counters, cleared on reset and on each accepted start.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_wait <= '0;
      stall_full <= '0;
    end else begin
      if (mem_read && mem_waitrequest) stall_wait <= sat_inc(stall_wait);
      if (elem_pend && chan_full)      stall_full <= sat_inc(stall_full);
    end
  end
`endif

endmodule

// File: tb/tb_burst_data_fetcher.sv
// Directed self-checking bench for burst_data_fetcher with a pipelined memory model.
// Build with FETCH_STATS_EN to also check the stall counters.
module tb_burst_data_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [63:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        mem_waitrequest;
  logic [7:0]  fifo_data;
  logic [3:0]  fifo_sel;
  logic        fifo_wren;
  logic [8:0]  fifo_full;
`ifdef FETCH_STATS_EN
  logic [15:0] stall_wait;
  logic [15:0] stall_full;
`endif

  always #5 clk = ~clk;

  burst_data_fetcher dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .base_addr         (base_addr),
    .busy              (busy),
    .done              (done),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_waitrequest   (mem_waitrequest),
    .fifo_data         (fifo_data),
    .fifo_sel          (fifo_sel),
    .fifo_wren         (fifo_wren),
    .fifo_full         (fifo_full)
`ifdef FETCH_STATS_EN
    ,
    .stall_wait        (stall_wait),
    .stall_full        (stall_full)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          lat;
  bit          wait_test;
  bit          full_test;
  bit          inject;
  logic [31:0] cur_base;

  int wr_count, done_count, acc_idx, resp_count, outstanding, max_out, last_wr_cyc;
  int stall_left, full_left;
  bit stall_done, full_done;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;
  rd_t pend[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word at address a: byte j (MS first) = {a[3:0], j+1}.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [63:0] w;
    logic [3:0]  hi;
    hi = a[3:0];
    w  = '0;
    for (int j = 0; j < 8; j++) w[63-8*j -: 8] = {hi, 4'(j + 1)};
    return w;
  endfunction

  function automatic logic [7:0] exp_data(input int i);
    logic [3:0] hi, lo;
    hi = 4'(i / 8);
    lo = 4'(i % 8 + 1);
    return {hi, lo};
  endfunction

  task automatic setup(input logic [31:0] base, input int latency, input bit wt, input bit ft);
    cur_base    = base;
    lat         = latency;
    wait_test   = wt;
    full_test   = ft;
    wr_count    = 0;
    done_count  = 0;
    acc_idx     = 0;
    resp_count  = 0;
    outstanding = 0;
    max_out     = 0;
    last_wr_cyc = -10;
    stall_left  = 0;
    stall_done  = 0;
    full_left   = 0;
    full_done   = 0;
  endtask

  // Memory slave, backpressure generator and FIFO-side monitor.
  initial begin
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    fifo_full         = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend.delete();
        outstanding       = 0;
        mem_readdatavalid = 1'b0;
        mem_waitrequest   = 1'b0;
        fifo_full         = '0;
      end else begin
        mem_waitrequest = 1'b0;
        if (wait_test && !stall_done && stall_left == 0 && mem_read && mem_address == cur_base + 32'd2)
          stall_left = 3;
        if (stall_left > 0) begin
          mem_waitrequest = 1'b1;
          stall_left--;
          if (stall_left == 0) stall_done = 1;
          check("wait_read_held", 64'(mem_read), 64'(1));
          check("wait_addr_held", 64'(mem_address), 64'(cur_base + 32'd2));
        end

        if (full_test && !full_done && full_left == 0 && wr_count == 24) full_left = 10;
        fifo_full = '0;
        if (full_left > 0) begin
          fifo_full[3] = 1'b1;
          full_left--;
          if (full_left == 0) full_done = 1;
        end

        mem_readdatavalid = 1'b0;
        if (inject) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = 64'hDEAD_BEEF_CAFE_F00D;
          inject            = 0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = mem_word(pend[0].addr);
          void'(pend.pop_front());
          outstanding--;
          resp_count++;
        end

        if (mem_read && !mem_waitrequest) begin
          check("rd_addr", 64'(mem_address), 64'(cur_base + 32'(acc_idx)));
          acc_idx++;
          pend.push_back('{mem_address, cyc + lat});
          outstanding++;
          if (outstanding > max_out) max_out = outstanding;
        end

        #1;
        if (fifo_full[3]) check("full_hold_no_wr", 64'(fifo_wren && fifo_sel == 4'd3), 64'(0));
        if (fifo_wren) begin
          check("wr_in_range", 64'(wr_count < 72), 64'(1));
          check("wr_sel", 64'(fifo_sel), 64'(wr_count / 8));
          check("wr_data", 64'(fifo_data), 64'(exp_data(wr_count)));
          wr_count++;
          last_wr_cyc = cyc;
        end
        if (done) begin
          done_count++;
          check("done_busy_low", 64'(busy), 64'(0));
          check("done_after_last_wr", 64'(cyc), 64'(last_wr_cyc + 1));
        end
      end
    end
  end

  task automatic do_run(input logic [31:0] base, input int latency, input bit wt, input bit ft,
                        input bit dbl);
    setup(base, latency, wt, ft);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 32'hFFFF_0000;
    check("busy_after_start", 64'(busy), 64'(1));
    check("read_after_start", 64'(mem_read), 64'(1));
    check("addr_after_start", 64'(mem_address), 64'(base));
    if (dbl) begin
      @(negedge clk);
      start     = 1'b1;
      base_addr = 32'h55;
      @(negedge clk);
      start     = 1'b0;
    end
    for (int i = 0; i < 3000 && done_count == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("done_once", 64'(done_count), 64'(1));
    check("wr_total", 64'(wr_count), 64'(72));
    check("reads_total", 64'(acc_idx), 64'(9));
    check("resps_total", 64'(resp_count), 64'(9));
    check("idle_after", 64'(busy), 64'(0));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    inject    = 0;
    setup(32'h0, 2, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_mem_read", 64'(mem_read), 64'(0));
    check("rst_mem_address", 64'(mem_address), 64'(0));
    check("rst_fifo_wren", 64'(fifo_wren), 64'(0));
    check("rst_fifo_data", 64'(fifo_data), 64'(0));
    check("rst_fifo_sel", 64'(fifo_sel), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Baseline image, two-cycle memory latency.
    do_run(32'h0, 2, 0, 0, 0);

    // Three-cycle waitrequest on word 2.
    do_run(32'h0, 2, 1, 0, 0);
`ifdef FETCH_STATS_EN
    check("stall_wait", 64'(stall_wait), 64'(3));
`endif

    // Channel 3 full for ten cycles.
    do_run(32'h0, 2, 0, 1, 0);

    // Long latency: pipelining limited by the credit pool.
    do_run(32'h0, 10, 0, 0, 0);
    check("max_outstanding", 64'(max_out), 64'(4));

    // Reset in the middle of a fetch.
    setup(32'h0, 2, 0, 0);
    @(negedge clk);
    start     = 1'b1;
    base_addr = 32'h0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && wr_count < 20; i++) @(negedge clk);
    check("reached_20_writes", 64'(wr_count >= 20), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_mem_read", 64'(mem_read), 64'(0));
    check("midrst_fifo_wren", 64'(fifo_wren), 64'(0));
    check("midrst_mem_address", 64'(mem_address), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    inject = 1;
    repeat (3) @(negedge clk);
    check("stray_rdv_no_wr", 64'(fifo_wren), 64'(0));
    check("stray_rdv_idle", 64'(busy), 64'(0));
    do_run(32'h100, 2, 0, 0, 0);

    // Start pulsed while busy is ignored.
    do_run(32'h0, 2, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
